// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers, with a busy/stall handshake.
// Optional macro MDU_DIV0_HOLD_EN: divide-by-zero retires at once and leaves HI/LO untouched.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUresult
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [31:0]   r_a, r_b, r_hi, r_lo;
    logic [3:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic          w_md_op, w_is_mul, w_accept, w_commit;
    logic [63:0]   w_smul, w_umul;
    logic [31:0]   w_sq, w_sr, w_res_hi, w_res_lo;

    assign w_md_op  = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign w_is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);

`ifdef MDU_DIV0_HOLD_EN
    // A zero-divisor divide is swallowed in its issue cycle: no busy window, no commit.
    assign w_accept = start && !r_busy && w_md_op && (w_is_mul || (SrcB != 32'd0));
`else
    assign w_accept = start && !r_busy && w_md_op;
`endif

    assign w_commit  = r_busy && (r_cnt == CW'(1));
    assign busy      = r_busy;
    assign stall_req = r_busy || (start && w_md_op);
    assign HI        = r_hi;
    assign LO        = r_lo;

    // Result is formed from the latched operands; only the commit edge is visible.
    assign w_smul = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_umul = {32'd0, r_a} * {32'd0, r_b};
    assign w_sq   = $signed(r_a) / $signed(r_b);
    assign w_sr   = $signed(r_a) % $signed(r_b);

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (r_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_smul;
            OP_MULTU: {w_res_hi, w_res_lo} = w_umul;
            OP_DIV, OP_DIVU: begin
                if (r_b == 32'd0) begin
                    w_res_hi = r_a;
                    w_res_lo = 32'hFFFF_FFFF;
                end else if (r_op == OP_DIVU) begin
                    w_res_hi = r_a % r_b;
                    w_res_lo = r_a / r_b;
                end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
                    // Signed overflow case pinned explicitly rather than left to the divider.
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_op   <= 4'd0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_a    <= SrcA;
                r_b    <= SrcB;
                r_op   <= mdu_op;
                r_cnt  <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_commit) begin
                    r_busy <= 1'b0;
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                end
            end
            if (start && !r_busy && mdu_op == OP_MTHI) r_hi <= SrcA;
            if (start && !r_busy && mdu_op == OP_MTLO) r_lo <= SrcA;
        end
    end

    always_comb begin
        MDUresult = 32'd0;
        if (mdu_op == OP_MFHI) MDUresult = r_hi;
        else if (mdu_op == OP_MFLO) MDUresult = r_lo;
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table run back-to-back through a HI/LO scoreboard,
// plus hand sequences for reset mid-op, mthi/mtlo/mfhi/mflo and issue-while-busy.
module tb_mdu;
    logic        clk, reset_n, start;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  mdu_op;
    logic        busy, stall_req;
    logic [31:0] HI, LO, MDUresult;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .SrcA(SrcA), .SrcB(SrcB), .mdu_op(mdu_op),
        .start(start), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO),
        .MDUresult(MDUresult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        inj;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] q_hi[$], q_lo[$];
    int          q_n[$];
    logic [31:0] m_hi, m_lo;
    int          n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Entered in the low half of a cycle; returns in the low half of the cycle busy first reads 0.
    task automatic run_md(input vec_t v);
        logic [31:0] eh, el, ph, pl;
        int n, pn, cnt;
        bit st_ok;
        eh = v.hi; el = v.lo;
        n  = (v.op <= 4'd2) ? 5 : 10;
`ifdef MDU_DIV0_HOLD_EN
        if (v.op >= 4'd3 && v.b == 32'd0) begin eh = m_hi; el = m_lo; n = 0; end
`endif
        q_hi.push_back(eh); q_lo.push_back(el); q_n.push_back(n);
        SrcA = v.a; SrcB = v.b; mdu_op = v.op; start = 1'b1;
        #1;
        chk("stall_issue", {31'd0, stall_req}, 32'd1);
        chk("busy_issue", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; SrcA = $urandom; SrcB = $urandom;
        cnt = 0; st_ok = 1'b1;
        while (busy === 1'b1 && cnt < 200) begin
            if (stall_req !== 1'b1) st_ok = 1'b0;
            if (v.inj && cnt == 2) begin start = 1'b1; mdu_op = 4'd1; end
            else if (v.inj && cnt == 3) begin start = 1'b1; mdu_op = 4'd5; end
            else begin start = 1'b0; mdu_op = 4'd0; end
            cnt++;
            @(negedge clk);
        end
        start = 1'b0; mdu_op = 4'd0;
        #1;
        ph = q_hi.pop_front(); pl = q_lo.pop_front(); pn = q_n.pop_front();
        chk("busy_cycles", 32'(cnt), 32'(pn));
        chk("stall_busy", {31'd0, st_ok}, 32'd1);
        chk("stall_done", {31'd0, stall_req}, 32'd0);
        chk("hi", HI, ph);
        chk("lo", LO, pl);
        m_hi = ph; m_lo = pl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1};
        tbl[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
        tbl[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
        tbl[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[5] = '{4'd3, 32'h0000_0055, 32'd0,         32'h0000_0055, 32'hFFFF_FFFF, 1'b0};
        tbl[6] = '{4'd4, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[7] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        tbl[8] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        tbl[9] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0};

        reset_n = 1'b0; start = 1'b0; mdu_op = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // mthi/mtlo then reads
        start = 1'b1; mdu_op = 4'd5; SrcA = 32'h1234_5678; #1;
        chk("stall_mthi", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd7; #1;
        chk("mfhi", MDUresult, 32'h1234_5678);
        chk("busy_mthi", {31'd0, busy}, 32'd0);
        start = 1'b1; mdu_op = 4'd6; SrcA = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd8; #1;
        chk("mflo", MDUresult, 32'hCAFE_F00D);
        mdu_op = 4'd7; #1;
        chk("mfhi_keep", MDUresult, 32'h1234_5678);
        mdu_op = 4'd0; #1;
        chk("mfnone", MDUresult, 32'd0);
        m_hi = 32'h1234_5678; m_lo = 32'hCAFE_F00D;
        @(negedge clk);

        // Vectors issued back-to-back, each in the cycle the previous one drops busy
        for (int i = 0; i < 10; i++) run_md(tbl[i]);
        mdu_op = 4'd7; #1;
        chk("mfhi_final", MDUresult, m_hi);
        mdu_op = 4'd8; #1;
        chk("mflo_final", MDUresult, m_lo);
        mdu_op = 4'd0;

        // Reset in the middle of a mult
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd1; SrcA = 32'd3; SrcB = 32'd4;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        @(negedge clk);
        reset_n = 1'b0; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; m_hi = 32'd0; m_lo = 32'd0;
        run_md('{4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0});
        repeat (12) @(negedge clk);
        chk("post_hi", HI, 32'd0);
        chk("post_lo", LO, 32'd12);
        chk("post_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
